// File: rtl/ram_bist_march.sv
// March C- BIST controller for one single-port RAM wrapper; compare pipeline captures the first failure.
// Optional BIST_CHECKERBOARD_EN appends a second March C- pass on an address-parity checkerboard background.
module ram_bist_march #(
  parameter int          WORDS = 1024,
  parameter int          AW    = 10,
  parameter int          DW    = 32,
  parameter logic [15:0] TRM   = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
`ifdef BIST_CHECKERBOARD_EN
  output logic          fail_pass2,
`endif
  output logic          cmbist,
  output logic          ramclk,
  output logic          ramcen,
  output logic          ramgwen,
  output logic [DW-1:0] ramwen,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramwdata,
  input  logic [DW-1:0] ramrdata,
  output logic [15:0]   ramtrm
);

  localparam logic [AW-1:0] TOP = AW'(WORDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_elem, w_nxt_elem;
  logic [AW-1:0]   r_addr, w_nxt_addr;
  logic            r_ph, w_nxt_ph;
  logic            r_pass, w_nxt_pass;
  logic            w_issue, w_last, w_down, w_addr_end, w_wr, w_bgv;
  logic [DW-1:0]   w_bg;
  logic            vld_p0, vld_p1;
  logic [DW-1:0]   r_exp_p0, r_exp_p1;
  logic [AW-1:0]   r_addr_p0, r_addr_p1;
  logic [2:0]      r_elem_p0, r_elem_p1;
`ifdef BIST_CHECKERBOARD_EN
  logic            r_pass_p0, r_pass_p1;
`endif

  // Pass 0 is solid 0/1; pass 1 is 0101.. flipped on odd addresses.
  function automatic logic [DW-1:0] f_bg(input logic v, input logic a0, input logic pass);
    logic [DW-1:0] p;
    for (int i = 0; i < DW; i++) p[i] = (i % 2 == 0);
    if (!pass) p = '0;
    else       p = p ^ {DW{a0}};
    return v ? ~p : p;
  endfunction

  assign ramclk = clk;
  assign ramtrm = TRM;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    cmbist = busy;
  end

  // Sequencer: (r_elem, r_addr, r_ph, r_pass) is the operation currently on the RAM pins.
  always_comb begin
    w_down     = (r_elem == 3'd3) || (r_elem == 3'd4);
    w_addr_end = w_down ? (r_addr == '0) : (r_addr == TOP);
`ifdef BIST_CHECKERBOARD_EN
    w_last     = (r_elem == 3'd5) && (r_addr == TOP) && r_pass;
`else
    w_last     = (r_elem == 3'd5) && (r_addr == TOP);
`endif
    w_issue    = 1'b0;
    w_nxt_elem = r_elem;
    w_nxt_addr = r_addr;
    w_nxt_ph   = r_ph;
    w_nxt_pass = r_pass;
    if (r_state == ST_IDLE && start) begin
      w_issue    = 1'b1;
      w_nxt_elem = 3'd0;
      w_nxt_addr = '0;
      w_nxt_ph   = 1'b0;
      w_nxt_pass = 1'b0;
    end else if (r_state == ST_RUN && !w_last) begin
      w_issue = 1'b1;
      if (r_elem >= 3'd1 && r_elem <= 3'd4 && !r_ph) begin
        w_nxt_ph = 1'b1;
      end else begin
        w_nxt_ph = 1'b0;
        if (w_addr_end) begin
          if (r_elem == 3'd5) begin
            w_nxt_elem = 3'd0;
            w_nxt_addr = '0;
            w_nxt_pass = 1'b1;
          end else begin
            w_nxt_elem = r_elem + 3'd1;
            w_nxt_addr = (r_elem == 3'd2 || r_elem == 3'd3) ? TOP : '0;
          end
        end else begin
          w_nxt_addr = w_down ? r_addr - 1'b1 : r_addr + 1'b1;
        end
      end
    end
    w_wr  = (w_nxt_elem == 3'd0) || w_nxt_ph;
    w_bgv = w_wr ? (w_nxt_elem == 3'd1 || w_nxt_elem == 3'd3)
                 : (w_nxt_elem == 3'd2 || w_nxt_elem == 3'd4);
    w_bg  = f_bg(w_bgv, w_nxt_addr[0], w_nxt_pass);
  end

  // Stage p0: operation registered onto the RAM pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_elem   <= '0;
      r_addr   <= '0;
      r_ph     <= 1'b0;
      r_pass   <= 1'b0;
      ramcen   <= 1'b1;
      ramgwen  <= 1'b1;
      ramwen   <= '1;
      ramaddr  <= '0;
      ramwdata <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p0 <= w_issue && !w_wr;
      vld_p1 <= vld_p0;
      if (w_issue) begin
        r_elem  <= w_nxt_elem;
        r_addr  <= w_nxt_addr;
        r_ph    <= w_nxt_ph;
        r_pass  <= w_nxt_pass;
        ramcen  <= 1'b0;
        ramgwen <= !w_wr;
        ramwen  <= {DW{!w_wr}};
        ramaddr <= w_nxt_addr;
        if (w_wr) ramwdata <= w_bg;
      end else begin
        ramcen  <= 1'b1;
        ramgwen <= 1'b1;
        ramwen  <= '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_exp_p0  <= w_bg;
    r_addr_p0 <= w_nxt_addr;
    r_elem_p0 <= w_nxt_elem;
`ifdef BIST_CHECKERBOARD_EN
    r_pass_p0 <= w_nxt_pass;
`endif
  end

  // Stage p1: RAM has sampled the read; data arrives for the compare below
  always_ff @(posedge clk) begin
    r_exp_p1  <= r_exp_p0;
    r_addr_p1 <= r_addr_p0;
    r_elem_p1 <= r_elem_p0;
`ifdef BIST_CHECKERBOARD_EN
    r_pass_p1 <= r_pass_p0;
`endif
  end

  // Stage p2: compare and sticky result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
`ifdef BIST_CHECKERBOARD_EN
      fail_pass2 <= 1'b0;
`endif
    end else if (r_state == ST_IDLE && start) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
`ifdef BIST_CHECKERBOARD_EN
      fail_pass2 <= 1'b0;
`endif
    end else begin
      if (r_state == ST_DRAIN) done <= 1'b1;
      if (vld_p1 && (ramrdata != r_exp_p1)) begin
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= r_addr_p1;
          fail_elem <= r_elem_p1;
        end
`ifdef BIST_CHECKERBOARD_EN
        if (r_pass_p1) fail_pass2 <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_march.sv
// Bench for ram_bist_march: behavioural RAM with one stuck-at fault, March C- reference model, vector table.
module tb_ram_bist_march;
  localparam int          WORDS = 16;
  localparam int          AW    = 5;
  localparam int          DW    = 32;
  localparam logic [15:0] TRM   = 16'hA5C3;
`ifdef BIST_CHECKERBOARD_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int OPS = 10 * WORDS * NPASS;

  logic          clk, reset, start;
  logic          busy, done, fail, cmbist, ramclk, ramcen, ramgwen;
  logic [AW-1:0] fail_addr, ramaddr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] ramwen, ramwdata, ramrdata;
  logic [15:0]   ramtrm;
`ifdef BIST_CHECKERBOARD_EN
  logic          fail_pass2;
`endif

  ram_bist_march #(.WORDS(WORDS), .AW(AW), .DW(DW), .TRM(TRM)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem),
`ifdef BIST_CHECKERBOARD_EN
    .fail_pass2(fail_pass2),
`endif
    .cmbist(cmbist), .ramclk(ramclk), .ramcen(ramcen), .ramgwen(ramgwen), .ramwen(ramwen),
    .ramaddr(ramaddr), .ramwdata(ramwdata), .ramrdata(ramrdata), .ramtrm(ramtrm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with an optional single stuck-at bit applied on read
  logic [DW-1:0] mem [WORDS];
  bit f_en, f_v;
  int f_a, f_b;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] w, input int a);
    if (f_en && a == f_a) w[f_b] = f_v;
    return w;
  endfunction

  always @(posedge clk) begin
    if (!ramcen && int'(ramaddr) < WORDS) begin
      if (!ramgwen) begin
        for (int i = 0; i < DW; i++) if (!ramwen[i]) mem[ramaddr][i] <= ramwdata[i];
      end else begin
        ramrdata <= faulty(mem[ramaddr], int'(ramaddr));
      end
    end
  end

  typedef struct { bit wr; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
  typedef struct { bit fen; int fa; int fb; bit fv; int mid; bit ef; int ea; int ee; bit ep2; } vec_t;

  op_t   exp_ops[$];
  vec_t  tbl[10];
  string march[6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
  string dir = "UUUDDU";
  int    checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] tb_bg(input bit v, input int a, input int pass);
    logic [DW-1:0] p;
    if (pass == 0) return v ? '1 : '0;
    for (int i = 0; i < DW; i++) p[i] = (i % 2 == 0);
    if (a % 2 == 1) p = ~p;
    return v ? ~p : p;
  endfunction

  // Reference: walk March C- element by element, building the op stream and the first failure
  task automatic build_ref(input bit fen, input int fa, input int fb, input bit fv,
                           output bit ef, output int ea, output int ee, output bit ep2);
    logic [DW-1:0] m [WORDS];
    ef = 0; ea = 0; ee = 0; ep2 = 0;
    exp_ops.delete();
    for (int p = 0; p < NPASS; p++)
      for (int e = 0; e < 6; e++)
        for (int i = 0; i < WORDS; i++) begin
          int a;
          a = (dir[e] == "D") ? WORDS - 1 - i : i;
          for (int k = 0; k < march[e].len() / 2; k++) begin
            bit wr, v;
            logic [DW-1:0] bgv, got;
            op_t o;
            wr  = (march[e][2*k] == "w");
            v   = (march[e][2*k+1] == "1");
            bgv = tb_bg(v, a, p);
            o.wr = wr; o.a = AW'(a); o.d = bgv;
            exp_ops.push_back(o);
            if (wr) m[a] = bgv;
            else begin
              got = m[a];
              if (fen && a == fa) got[fb] = fv;
              if (got !== bgv) begin
                if (!ef) begin ef = 1; ea = a; ee = e; end
                if (p == 1) ep2 = 1;
              end
            end
          end
        end
  endtask

  task automatic run_test(input vec_t v, input int idx);
    bit ef, ep2;
    int ea, ee, n, busy_cnt, opi, op_bad, cm_bad, done_edge, first_bad;
    logic [DW-1:0] w2;
    string nm;
    f_en = v.fen; f_a = v.fa; f_b = v.fb; f_v = v.fv;
    build_ref(v.fen, v.fa, v.fb, v.fv, ef, ea, ee, ep2);
    busy_cnt = 0; opi = 0; op_bad = 0; cm_bad = 0; done_edge = -1; first_bad = -1; n = 0; w2 = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nm = $sformatf("v%0d", idx);
    chk({nm, "_accept_done"}, done, 0);
    chk({nm, "_accept_fail"}, fail, 0);
    while (done_edge < 0 && n <= OPS + 20) begin
      if (busy) busy_cnt++;
      if (cmbist !== busy) cm_bad++;
      if (!ramcen) begin
        if (opi == 10 * WORDS + 1) w2 = ramwdata;
        if (opi >= exp_ops.size() || ramaddr !== exp_ops[opi].a || (!ramgwen) !== exp_ops[opi].wr ||
            ramwen !== {DW{!exp_ops[opi].wr}} || (exp_ops[opi].wr && ramwdata !== exp_ops[opi].d)) begin
          op_bad++;
          if (first_bad < 0) first_bad = opi;
        end
        opi++;
      end
      if (done) done_edge = n + 1;
      else begin
        start = (n == v.mid - 1);
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    chk({nm, "_done_edge"}, done_edge, OPS + 2);
    chk({nm, "_busy_cycles"}, busy_cnt, OPS + 1);
    chk({nm, "_cen_low_cycles"}, opi, OPS);
    chk({nm, "_op_seq_bad"}, op_bad, 0);
    chk({nm, "_cmbist_vs_busy"}, cm_bad, 0);
    chk({nm, "_fail"}, fail, v.ef);
    if (v.ef) begin
      chk({nm, "_fail_addr"}, fail_addr, v.ea);
      chk({nm, "_fail_elem"}, fail_elem, v.ee);
    end
`ifdef BIST_CHECKERBOARD_EN
    chk({nm, "_fail_pass2"}, fail_pass2, v.ep2);
    chk({nm, "_pass2_addr1_data"}, w2, 32'hAAAA_AAAA);
`endif
    @(posedge clk); #1;
    chk({nm, "_post_busy"}, busy, 0);
    chk({nm, "_post_done_sticky"}, done, 1);
    chk({nm, "_post_cen"}, ramcen, 1);
  endtask

  initial begin
    bit ef, ep2;
    int ea, ee, cen_cnt;
    reset = 1'b1; start = 1'b0; f_en = 0; f_a = 0; f_b = 0; f_v = 0;
    for (int i = 0; i < WORDS; i++) mem[i] = {$urandom, $urandom};
    ramrdata = '0;

    // Hand-written table entries from the known March C- detection points
    tbl[0] = '{fen:0, fa:0,  fb:0, fv:0, mid:-1, ef:0, ea:0,  ee:0, ep2:0};
    tbl[1] = '{fen:1, fa:5,  fb:3, fv:1, mid:-1, ef:1, ea:5,  ee:1, ep2:(NPASS == 2)};
    tbl[2] = '{fen:0, fa:0,  fb:0, fv:0, mid:20, ef:0, ea:0,  ee:0, ep2:0};
    tbl[3] = '{fen:1, fa:15, fb:0, fv:0, mid:-1, ef:1, ea:15, ee:2, ep2:(NPASS == 2)};
    for (int i = 4; i < 10; i++) begin
      tbl[i].fen = 1;
      tbl[i].fa  = $urandom_range(0, WORDS - 1);
      tbl[i].fb  = $urandom_range(0, DW - 1);
      tbl[i].fv  = $urandom_range(0, 1);
      tbl[i].mid = (i % 2 == 0) ? $urandom_range(1, OPS + 1) : -1;
      build_ref(1, tbl[i].fa, tbl[i].fb, tbl[i].fv, ef, ea, ee, ep2);
      tbl[i].ef = ef; tbl[i].ea = ea; tbl[i].ee = ee; tbl[i].ep2 = ep2;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_cmbist", cmbist, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_elem", fail_elem, 0);
    chk("rst_cen", ramcen, 1);
    chk("rst_gwen", ramgwen, 1);
    chk("rst_wen", ramwen, {DW{1'b1}});
    chk("rst_addr", ramaddr, 0);
    chk("rst_wdata", ramwdata, 0);
    chk("trm", ramtrm, TRM);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_test(tbl[i], i);

    // Reset in the middle of a faulty run
    f_en = 1; f_a = 5; f_b = 3; f_v = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k < 40; k++) begin @(posedge clk); #1; end
    chk("midrst_pre_busy", busy, 1);
    chk("midrst_pre_fail", fail, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cmbist", cmbist, 0);
    chk("midrst_cen", ramcen, 1);
    chk("midrst_done", done, 0);
    chk("midrst_fail", fail, 0);
    reset = 1'b0;
    cen_cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (!ramcen || busy) cen_cnt++;
    end
    chk("midrst_no_access", cen_cnt, 0);
    run_test(tbl[0], 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
